// File: rtl/k052591_loader.sv
// Program loader and run sequencer for the 052591 PMC: replays 36-bit microcode words as PMC bus writes.
// Optional K052591_LDR_OUT0_DONE_EN: a synchronized PMC OUT0 low for 2 cycles also ends a run.
module k052591_loader #(
  parameter int STROBE_LEN = 2
) (
  input  logic        pin_M12,
  input  logic        pin_RST,
  input  logic        load_go,
  input  logic [5:0]  load_addr,
  input  logic        w_valid,
  input  logic [35:0] w_data,
  input  logic        w_last,
  output logic        w_ready,
  input  logic        run_go,
  input  logic        run_stop,
  output logic        busy,
  output logic        load_done,
  output logic        run_done,
  output logic        ovf,
  output logic        pin_CS,
  output logic        pin_NRD,
  output logic        pin_BK,
  output logic        pin_START,
  output logic [12:0] pin_AB,
  output logic [7:0]  pin_DB_out,
  output logic        pin_DB_oe,
  input  logic        pin_OUT0
);

  // state      | meaning
  // IDLE       | waiting for load_go / run_go
  // PC_*       | set-PC write of the load start address
  // WAIT_WORD  | w_ready high, waiting for a microcode word
  // B_*        | one byte write of the captured word
  // ARM_*      | write of 8'h80 forcing PC=0
  // RUN        | START held high until the run ends
  typedef enum logic [3:0] {
    IDLE, PC_SETUP, PC_STROBE, PC_HOLD, WAIT_WORD, B_SETUP, B_STROBE, B_HOLD,
    ARM_SETUP, ARM_STROBE, ARM_HOLD, RUN
  } state_t;

  state_t      state, state_n;
  logic [3:0]  stb_cnt;
  logic [2:0]  byte_cnt, byte_sel;
  logic [35:0] w_q, src;
  logic        last_q;
  logic [6:0]  word_cnt;
  logic [7:0]  db_byte;
  logic        accept, stop_req;

  assign accept  = (state == WAIT_WORD) && w_valid;
  assign pin_NRD = 1'b1;
  assign pin_BK  = 1'b0;

`ifdef K052591_LDR_OUT0_DONE_EN
  logic [1:0] out0_sync;
  logic [2:0] blank_cnt;
  logic       out0_low_q, out0_elig;

  assign out0_elig = (state == RUN) && (blank_cnt == 3'd0) && !out0_sync[1];
  assign stop_req  = run_stop || (out0_elig && out0_low_q);

  // blank_cnt masks OUT0 during the first 4 RUN cycles (PMC start latency)
  always_ff @(posedge pin_M12 or posedge pin_RST) begin
    if (pin_RST) begin
      out0_sync  <= 2'b11;
      blank_cnt  <= 3'd4;
      out0_low_q <= 1'b0;
    end else begin
      out0_sync  <= {out0_sync[0], pin_OUT0};
      out0_low_q <= out0_elig;
      if (state != RUN)
        blank_cnt <= 3'd4;
      else if (blank_cnt != 3'd0)
        blank_cnt <= blank_cnt - 3'd1;
    end
  end
`else
  logic unused_out0;
  assign unused_out0 = pin_OUT0;
  assign stop_req    = run_stop;
`endif

  always_ff @(posedge pin_M12 or posedge pin_RST) begin
    if (pin_RST) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:       if (load_go) state_n = PC_SETUP;
                  else if (run_go) state_n = ARM_SETUP;
      PC_SETUP:   state_n = PC_STROBE;
      PC_STROBE:  if (stb_cnt == 4'd0) state_n = PC_HOLD;
      PC_HOLD:    state_n = WAIT_WORD;
      WAIT_WORD:  if (w_valid) state_n = B_SETUP;
      B_SETUP:    state_n = B_STROBE;
      B_STROBE:   if (stb_cnt == 4'd0) state_n = B_HOLD;
      B_HOLD:     if (byte_cnt != 3'd4) state_n = B_SETUP;
                  else state_n = last_q ? IDLE : WAIT_WORD;
      ARM_SETUP:  state_n = ARM_STROBE;
      ARM_STROBE: if (stb_cnt == 4'd0) state_n = ARM_HOLD;
      ARM_HOLD:   state_n = RUN;
      RUN:        if (stop_req) state_n = IDLE;
      default:    state_n = IDLE;
    endcase
  end

  // Byte for the next B_SETUP; on the accept edge the word is not yet in w_q
  always_comb begin
    src      = (state == WAIT_WORD) ? w_data : w_q;
    byte_sel = (state == WAIT_WORD) ? 3'd0 : byte_cnt + 3'd1;
    case (byte_sel)
      3'd0:    db_byte = src[7:0];
      3'd1:    db_byte = src[15:8];
      3'd2:    db_byte = src[23:16];
      3'd3:    db_byte = src[31:24];
      default: db_byte = {4'h0, src[35:32]};
    endcase
  end

  always_ff @(posedge pin_M12 or posedge pin_RST) begin
    if (pin_RST) begin
      stb_cnt  <= 4'd0;
      byte_cnt <= 3'd0;
      w_q      <= 36'd0;
      last_q   <= 1'b0;
      word_cnt <= 7'd0;
      ovf      <= 1'b0;
    end else begin
      if (state == PC_SETUP || state == B_SETUP || state == ARM_SETUP)
        stb_cnt <= 4'(STROBE_LEN - 1);
      else if (stb_cnt != 4'd0)
        stb_cnt <= stb_cnt - 4'd1;
      if (accept) begin
        byte_cnt <= 3'd0;
        w_q      <= w_data;
        last_q   <= w_last;
      end else if (state == B_HOLD && state_n == B_SETUP) begin
        byte_cnt <= byte_cnt + 3'd1;
      end
      // word_cnt saturates at 64; any further word in the same load is an overflow
      if (state == IDLE && load_go) begin
        word_cnt <= 7'd0;
        ovf      <= 1'b0;
      end else if (accept) begin
        if (word_cnt[6]) ovf <= 1'b1;
        else             word_cnt <= word_cnt + 7'd1;
      end
    end
  end

  always_ff @(posedge pin_M12 or posedge pin_RST) begin
    if (pin_RST) begin
      pin_CS     <= 1'b1;
      pin_START  <= 1'b0;
      pin_AB     <= 13'd0;
      pin_DB_out <= 8'd0;
      pin_DB_oe  <= 1'b0;
      w_ready    <= 1'b0;
      busy       <= 1'b0;
      load_done  <= 1'b0;
      run_done   <= 1'b0;
    end else begin
      pin_CS    <= !(state_n == PC_STROBE || state_n == B_STROBE || state_n == ARM_STROBE);
      pin_START <= (state_n == RUN);
      w_ready   <= (state_n == WAIT_WORD);
      busy      <= (state_n != IDLE);
      load_done <= (state == B_HOLD) && (state_n == IDLE);
      run_done  <= (state == RUN) && (state_n == IDLE);
      case (state_n)
        PC_SETUP: begin
          pin_AB     <= 13'h0200;
          pin_DB_out <= {2'b00, load_addr};
          pin_DB_oe  <= 1'b1;
        end
        ARM_SETUP: begin
          pin_AB     <= 13'h0200;
          pin_DB_out <= 8'h80;
          pin_DB_oe  <= 1'b1;
        end
        B_SETUP: begin
          pin_AB     <= 13'h0000;
          pin_DB_out <= db_byte;
          pin_DB_oe  <= 1'b1;
        end
        PC_STROBE, PC_HOLD, B_STROBE, B_HOLD, ARM_STROBE, ARM_HOLD: ;
        default: begin
          pin_AB     <= 13'h0000;
          pin_DB_out <= 8'h00;
          pin_DB_oe  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_k052591_loader.sv
// Self-checking bench for k052591_loader: bus writes are captured at each CS pulse and
// compared against a byte-list model built from the words fed in.
module tb_k052591_loader;
  localparam int SL = 2;

  logic        clk = 1'b0, rst = 1'b1;
  logic        load_go = 0, w_valid = 0, w_last = 0, run_go = 0, run_stop = 0, out0 = 1;
  logic [5:0]  load_addr = 0;
  logic [35:0] w_data = 0;
  logic        w_ready, busy, load_done, run_done, ovf;
  logic        pin_CS, pin_NRD, pin_BK, pin_START, pin_DB_oe;
  logic [12:0] pin_AB;
  logic [7:0]  pin_DB_out;

  k052591_loader #(.STROBE_LEN(SL)) dut (
    .pin_M12(clk), .pin_RST(rst), .load_go(load_go), .load_addr(load_addr),
    .w_valid(w_valid), .w_data(w_data), .w_last(w_last), .w_ready(w_ready),
    .run_go(run_go), .run_stop(run_stop), .busy(busy), .load_done(load_done),
    .run_done(run_done), .ovf(ovf), .pin_CS(pin_CS), .pin_NRD(pin_NRD), .pin_BK(pin_BK),
    .pin_START(pin_START), .pin_AB(pin_AB), .pin_DB_out(pin_DB_out), .pin_DB_oe(pin_DB_oe),
    .pin_OUT0(out0));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [12:0] ab;
    logic [7:0]  db;
    logic        oe;
    logic [7:0]  len;
  } rec_t;

  rec_t        recs[$], expq[$], cur;
  logic [35:0] words[$];
  int checks = 0, failures = 0;
  int cyc = 0, lowlen = 0, last_rise = 0, done_cyc = 0, done_cnt = 0, rdone_cnt = 0;
  bit start_seen = 0;

  // Bus monitor: one record per CS-low pulse
  always @(negedge clk) begin
    cyc++;
    if (load_done) begin done_cnt++; done_cyc = cyc; end
    if (run_done) rdone_cnt++;
    if (pin_START) start_seen = 1;
    if (!pin_CS) begin
      lowlen++;
      cur.ab = pin_AB; cur.db = pin_DB_out; cur.oe = pin_DB_oe;
    end else if (lowlen > 0) begin
      cur.len = 8'(lowlen);
      recs.push_back(cur);
      lowlen = 0;
      last_rise = cyc;
    end
  end

  function automatic rec_t mk(input logic [12:0] ab, input logic [7:0] db);
    rec_t r;
    r.ab = ab; r.db = db; r.oe = 1'b1; r.len = 8'(SL);
    return r;
  endfunction

  // Model: set-PC write, then every word split into five little-endian bytes
  task automatic build_exp(input logic [5:0] addr);
    expq.push_back(mk(13'h200, {2'b00, addr}));
    foreach (words[i])
      for (int b = 0; b < 5; b++)
        expq.push_back(mk(13'h0, 8'((words[i] >> (8 * b)) & 36'hff)));
  endtask

  task automatic send_word(input logic [35:0] d, input logic last);
    int to = 0;
    w_valid = 1; w_data = d; w_last = last;
    @(negedge clk);
    while (!w_ready && to < 2000) begin @(negedge clk); to++; end
    checks++;
    if (to >= 2000) begin failures++; $display("FAIL word_accept timeout actual=no_ready required=ready"); end
    @(posedge clk); #1;
    w_valid = 0;
  endtask

  task automatic pulse_load(input logic [5:0] addr);
    @(posedge clk); #1; load_go = 1; load_addr = addr;
    @(posedge clk); #1; load_go = 0;
  endtask

  task automatic wait_idle();
    int to = 0;
    @(negedge clk);
    while (busy && to < 5000) begin @(negedge clk); to++; end
    checks++;
    if (to >= 5000) begin failures++; $display("FAIL idle_timeout actual=busy required=idle"); end
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_all();
    recs.delete(); expq.delete(); words.delete();
  endtask

  task automatic test_reset();
    #12;
    checks++; if ({pin_CS, pin_NRD, pin_BK, pin_START} !== 4'b1100) begin failures++;
      $display("FAIL reset_pins actual=%b required=1100", {pin_CS, pin_NRD, pin_BK, pin_START}); end
    checks++; if ({pin_AB, pin_DB_out, pin_DB_oe} !== 22'd0) begin failures++;
      $display("FAIL reset_bus actual=%h/%h/%b required=0", pin_AB, pin_DB_out, pin_DB_oe); end
    checks++; if ({w_ready, busy, load_done, run_done, ovf} !== 5'd0) begin failures++;
      $display("FAIL reset_status actual=%b required=00000", {w_ready, busy, load_done, run_done, ovf}); end
    @(posedge clk); #1; rst = 0;
    repeat (2) @(negedge clk);
    recs.delete();
  endtask

  task automatic test_single();
    int lat = 0, d0;
    clear_all();
    words.push_back(36'h987654321);
    build_exp(6'd5);
    d0 = done_cnt;
    @(posedge clk); #1; load_go = 1; load_addr = 6'd5;
    w_valid = 1; w_data = 36'h987654321; w_last = 1;
    do begin
      @(posedge clk); #1; lat++;
      load_go = 0;
    end while (pin_CS && lat < 10);
    checks++; if (lat != 2) begin failures++; $display("FAIL cs_latency actual=%0d required=2", lat); end
    send_word(36'h987654321, 1'b1);
    wait_idle();
    checks++; if (recs.size() != 6) begin failures++;
      $display("FAIL single_count actual=%0d required=6", recs.size()); end
    for (int i = 0; i < 6 && i < recs.size(); i++) begin
      checks++; if (recs[i] !== expq[i]) begin failures++;
        $display("FAIL single_write%0d actual=%h required=%h", i, recs[i], expq[i]); end
    end
    checks++; if (done_cnt - d0 != 1) begin failures++;
      $display("FAIL single_done_pulses actual=%0d required=1", done_cnt - d0); end
    checks++; if (done_cyc != last_rise + 1) begin failures++;
      $display("FAIL done_timing actual=%0d required=%0d", done_cyc, last_rise + 1); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy actual=%b required=0", busy); end
  endtask

  task automatic test_random();
    logic [5:0] addr;
    int n, bad;
    for (int it = 0; it < 4; it++) begin
      clear_all();
      addr = 6'($urandom_range(63, 0));
      n = $urandom_range(4, 1);
      for (int k = 0; k < n; k++) words.push_back({4'($urandom), 32'($urandom)});
      build_exp(addr);
      pulse_load(addr);
      for (int k = 0; k < n; k++) begin
        repeat ($urandom_range(3, 0)) begin @(posedge clk); #1; end
        send_word(words[k], k == n - 1);
      end
      wait_idle();
      bad = 0;
      if (recs.size() != expq.size()) bad = 1;
      else foreach (recs[i]) if (recs[i] !== expq[i]) bad = 1;
      checks++; if (bad) begin failures++;
        $display("FAIL random_load%0d actual_writes=%0d required_writes=%0d", it, recs.size(), expq.size()); end
    end
  endtask

  task automatic test_backpressure();
    int bad = 0, to = 0;
    clear_all();
    words.push_back(36'h0A1B2C3D4); words.push_back(36'hF00DCAFE5);
    build_exp(6'd17);
    pulse_load(6'd17);
    send_word(words[0], 1'b0);
    @(negedge clk);
    while (!w_ready && to < 200) begin @(negedge clk); to++; end
    repeat (10) begin
      if (pin_CS !== 1'b1 || w_ready !== 1'b1) bad++;
      @(negedge clk);
    end
    checks++; if (bad != 0) begin failures++;
      $display("FAIL gap_idle actual=%0d_bad_cycles required=0", bad); end
    @(posedge clk); #1;
    send_word(words[1], 1'b1);
    wait_idle();
    bad = (recs.size() != 11);
    if (!bad) foreach (recs[i]) if (recs[i] !== expq[i]) bad = 1;
    checks++; if (bad) begin failures++;
      $display("FAIL gap_writes actual=%0d required=11", recs.size()); end
  endtask

  task automatic test_overflow();
    int bad = 0;
    clear_all();
    for (int k = 0; k < 65; k++) words.push_back({4'($urandom), 32'($urandom)});
    build_exp(6'd0);
    pulse_load(6'd0);
    for (int k = 0; k < 65; k++) begin
      send_word(words[k], k == 64);
      if (k == 63) begin checks++; if (ovf !== 1'b0) begin failures++;
        $display("FAIL ovf_after64 actual=%b required=0", ovf); end end
      if (k == 64) begin checks++; if (ovf !== 1'b1) begin failures++;
        $display("FAIL ovf_after65 actual=%b required=1", ovf); end end
    end
    wait_idle();
    if (recs.size() != 326) bad = 1;
    else foreach (recs[i]) if (recs[i] !== expq[i]) bad = 1;
    checks++; if (bad) begin failures++;
      $display("FAIL ovf_writes actual=%0d required=326", recs.size()); end
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_sticky actual=%b required=1", ovf); end
    clear_all();
    pulse_load(6'd3);
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL ovf_clear actual=%b required=0", ovf); end
    send_word(36'h123456789, 1'b1);
    wait_idle();
  endtask

  task automatic test_run();
    int to = 0, r0;
    clear_all();
    r0 = rdone_cnt;
    @(posedge clk); #1; run_go = 1;
    @(posedge clk); #1; run_go = 0;
    @(negedge clk);
    while (!pin_START && to < 100) begin @(negedge clk); to++; end
    checks++; if (recs.size() != 1 || recs[0] !== mk(13'h200, 8'h80)) begin failures++;
      $display("FAIL arm_write actual_n=%0d required=1x(200,80)", recs.size()); end
    checks++; if (pin_START !== 1'b1 || busy !== 1'b1) begin failures++;
      $display("FAIL run_start actual=%b%b required=11", pin_START, busy); end
    repeat (5) @(posedge clk);
    #1; run_stop = 1;
    @(posedge clk); #1; run_stop = 0;
    @(negedge clk);
    checks++; if ({pin_START, run_done, busy} !== 3'b010) begin failures++;
      $display("FAIL run_stop actual=%b required=010", {pin_START, run_done, busy}); end
    @(negedge clk);
    checks++; if (rdone_cnt - r0 != 1) begin failures++;
      $display("FAIL run_done_pulses actual=%0d required=1", rdone_cnt - r0); end
    clear_all();
    start_seen = 0;
    words.push_back(36'h5A5A5A5A5);
    build_exp(6'd9);
    @(posedge clk); #1; load_go = 1; run_go = 1; load_addr = 6'd9;
    @(posedge clk); #1; load_go = 0; run_go = 0;
    send_word(words[0], 1'b1);
    wait_idle();
    repeat (5) @(negedge clk);
    checks++; if (recs.size() != 6 || recs[0] !== expq[0] || start_seen) begin failures++;
      $display("FAIL load_priority actual_n=%0d start=%b required=6/0", recs.size(), start_seen); end
  endtask

  task automatic test_midreset();
    int to = 0;
    clear_all();
    pulse_load(6'd12);
    send_word(36'hDEADBEEF7, 1'b1);
    while (!(recs.size() == 3 && !pin_CS) && to < 200) begin @(negedge clk); to++; end
    checks++; if (to >= 200) begin failures++; $display("FAIL midreset_reach actual=timeout required=byte2"); end
    #2; rst = 1;
    #1;
    checks++; if ({pin_CS, busy, pin_START} !== 3'b100) begin failures++;
      $display("FAIL midreset_async actual=%b required=100", {pin_CS, busy, pin_START}); end
    @(posedge clk); #1; rst = 0;
    repeat (2) @(negedge clk);
    clear_all();
    words.push_back(36'h0000000AB);
    build_exp(6'd40);
    pulse_load(6'd40);
    send_word(words[0], 1'b1);
    wait_idle();
    checks++; if (recs.size() != 6 || recs[0] !== expq[0] || recs[1] !== expq[1]) begin failures++;
      $display("FAIL reload_setpc actual_n=%0d required=6", recs.size()); end
  endtask

`ifdef K052591_LDR_OUT0_DONE_EN
  task automatic test_out0();
    int to = 0, r0;
    r0 = rdone_cnt;
    @(posedge clk); #1; run_go = 1;
    @(posedge clk); #1; run_go = 0;
    @(negedge clk);
    while (!pin_START && to < 100) begin @(negedge clk); to++; end
    @(posedge clk); #1; out0 = 0;
    @(posedge clk); #1;
    @(posedge clk); #1; out0 = 1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++; if (pin_START !== 1'b1) begin failures++; $display("FAIL out0_blank actual=%b required=1", pin_START); end
    repeat (2) @(posedge clk);
    #1; out0 = 0;
    repeat (2) @(posedge clk);
    #1; out0 = 1;
    to = 0;
    @(negedge clk);
    while (pin_START && to < 20) begin @(negedge clk); to++; end
    repeat (2) @(negedge clk);
    checks++; if (pin_START !== 1'b0 || rdone_cnt - r0 != 1) begin failures++;
      $display("FAIL out0_done actual=%b/%0d required=0/1", pin_START, rdone_cnt - r0); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_random();
    test_backpressure();
    test_overflow();
    test_run();
    test_midreset();
`ifdef K052591_LDR_OUT0_DONE_EN
    test_out0();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
